// File: rtl/cla_sum_serializer.sv
// Serializes a parallel CLA result word as a framed LSB-first bitstream:
// start bit, WIDTH data bits, optional even-parity bit, stop bit.
module cla_sum_serializer #(
    parameter int WIDTH     = 6,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             SOUT,
    output logic             SOUT_FRAME,
    output logic             BUSY,
    output logic             DONE
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             par_bit;
    logic             take;

    assign take = DIN_VALID && DIN_READY;

    // Every output is registered with the value belonging to the state being entered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            SOUT       <= 1'b1;
            SOUT_FRAME <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            DIN_READY  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE, STOP: begin
                    if (take) begin
                        state      <= START;
                        shreg      <= DIN;
                        par_bit    <= ^DIN;
                        bit_cnt    <= '0;
                        SOUT       <= 1'b0;
                        SOUT_FRAME <= 1'b1;
                        BUSY       <= 1'b1;
                        DIN_READY  <= 1'b0;
                    end else begin
                        state      <= IDLE;
                        SOUT       <= 1'b1;
                        SOUT_FRAME <= 1'b0;
                        BUSY       <= 1'b0;
                        DIN_READY  <= 1'b1;
                    end
                end
                START: begin
                    state <= DATA;
                    SOUT  <= shreg[0];
                    shreg <= shreg >> 1;
                end
                DATA: begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY_EN) begin
                            state <= PARITY;
                            SOUT  <= par_bit;
                        end else begin
                            state     <= STOP;
                            SOUT      <= 1'b1;
                            DONE      <= 1'b1;
                            DIN_READY <= 1'b1;
                        end
                    end else begin
                        SOUT  <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
                PARITY: begin
                    state     <= STOP;
                    SOUT      <= 1'b1;
                    DONE      <= 1'b1;
                    DIN_READY <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    SOUT       <= 1'b1;
                    SOUT_FRAME <= 1'b0;
                    BUSY       <= 1'b0;
                    DIN_READY  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_sum_serializer.sv
// Bench for cla_sum_serializer: one instance without parity, one with parity,
// sharing the input side and each tracked by a frame-list reference model.
module tb_cla_sum_serializer;

    localparam int W = 6;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] alt;   // value put on DIN mid-frame; must not affect the frame
        logic [0:7]   seq;   // no-parity frame in time order: start, d0..d5, stop
        logic         par;   // expected parity bit
    } vec_t;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic [W-1:0] din       = '0;
    logic         din_valid = 1'b0;

    logic ready0, sout0, frame0, busy0, done0;
    logic ready1, sout1, frame1, busy1, done1;
    logic [1:0] ready_v, sout_v, frame_v, busy_v, done_v;

    assign ready_v = {ready1, ready0};
    assign sout_v  = {sout1, sout0};
    assign frame_v = {frame1, frame0};
    assign busy_v  = {busy1, busy0};
    assign done_v  = {done1, done0};

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cla_sum_serializer #(.WIDTH(W), .PARITY_EN(1'b0)) dut_np (
        .CLK(clk), .RST_N(rst_n), .DIN(din), .DIN_VALID(din_valid),
        .DIN_READY(ready0), .SOUT(sout0), .SOUT_FRAME(frame0), .BUSY(busy0), .DONE(done0)
    );

    cla_sum_serializer #(.WIDTH(W), .PARITY_EN(1'b1)) dut_p (
        .CLK(clk), .RST_N(rst_n), .DIN(din), .DIN_VALID(din_valid),
        .DIN_READY(ready1), .SOUT(sout1), .SOUT_FRAME(frame1), .BUSY(busy1), .DONE(done1)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_sout%0d", tag, i), sout_v[i], 1'b1);
            check($sformatf("%s_frame%0d", tag, i), frame_v[i], 1'b0);
            check($sformatf("%s_busy%0d", tag, i), busy_v[i], 1'b0);
            check($sformatf("%s_done%0d", tag, i), done_v[i], 1'b0);
            check($sformatf("%s_ready%0d", tag, i), ready_v[i], 1'b0);
        end
    endtask

    // Reference model: a frame is a list of line values; pos indexes the bit on the line.
    int   pos[2]  = '{-1, -1};
    int   flen[2] = '{W + 2, W + 3};
    logic fb[2][0:W+2];
    bit   live[2] = '{1'b0, 1'b0};
    bit   m_rdy;
    logic e_sout, e_frame, e_done, e_ready;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                pos[i]  = -1;
                live[i] = 1'b0;
            end else begin
                m_rdy   = live[i] && (pos[i] < 0 || pos[i] == flen[i] - 1);
                live[i] = 1'b1;
                if (din_valid && m_rdy) begin
                    fb[i][0] = 1'b0;
                    for (int b = 0; b < W; b++) fb[i][1 + b] = din[b];
                    if (i == 1) fb[i][W + 1] = ^din;
                    fb[i][flen[i] - 1] = 1'b1;
                    pos[i] = 0;
                end else if (pos[i] >= 0) begin
                    pos[i]++;
                    if (pos[i] >= flen[i]) pos[i] = -1;
                end
            end
        end
        #2;
        for (int i = 0; i < 2; i++) begin
            e_sout  = (pos[i] < 0) ? 1'b1 : fb[i][pos[i]];
            e_frame = (pos[i] >= 0);
            e_done  = (pos[i] >= 0) && (pos[i] == flen[i] - 1);
            e_ready = live[i] && (pos[i] < 0 || pos[i] == flen[i] - 1);
            check($sformatf("model_sout%0d", i), sout_v[i], e_sout);
            check($sformatf("model_frame%0d", i), frame_v[i], e_frame);
            check($sformatf("model_busy%0d", i), busy_v[i], e_frame);
            check($sformatf("model_done%0d", i), done_v[i], e_done);
            check($sformatf("model_ready%0d", i), ready_v[i], e_ready);
        end
    end

    // Called on a falling edge with both instances idle; returns likewise.
    task automatic run_entry(input vec_t v);
        logic e_np, e_p;
        din       = v.din;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int t = 0; t < 10; t++) begin
            e_np = (t < 8) ? v.seq[t] : 1'b1;
            if (t < 7)       e_p = v.seq[t];
            else if (t == 7) e_p = v.par;
            else             e_p = 1'b1;
            check("tbl_sout_np", sout0, e_np);
            check("tbl_sout_p", sout1, e_p);
            check("tbl_done_np", done0, t == 7);
            check("tbl_done_p", done1, t == 8);
            check("tbl_frame_np", frame0, t < 8);
            check("tbl_frame_p", frame1, t < 9);
            if (t == 1) din = v.alt;
            if (t < 9) @(negedge clk);
        end
    endtask

    initial begin
        vec_t tbl[6];
        logic e_b;
        tbl[0] = '{6'b101101, 6'b101101, 8'b01011011, 1'b0};
        tbl[1] = '{6'b000111, 6'b000111, 8'b01110001, 1'b1};
        tbl[2] = '{6'h3F,     6'h3F,     8'b01111111, 1'b0};
        tbl[3] = '{6'h00,     6'h00,     8'b00000001, 1'b0};
        tbl[4] = '{6'h2A,     6'h15,     8'b00101011, 1'b1};
        tbl[5] = '{6'h15,     6'h15,     8'b01010101, 1'b1};

        // Reset held with a pending word
        din       = 6'h3F;
        din_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_reset_outs("rst_hold");
        end
        rst_n     = 1'b1;
        din_valid = 1'b0;
        check("rdy_before_edge0", ready0, 1'b0);
        check("rdy_before_edge1", ready1, 1'b0);
        @(negedge clk);
        check("rdy_after_edge0", ready0, 1'b1);
        check("rdy_after_edge1", ready1, 1'b1);

        foreach (tbl[k]) run_entry(tbl[k]);

        // Back-to-back frames with DIN_VALID held high
        din       = 6'h3F;
        din_valid = 1'b1;
        @(negedge clk);
        din = 6'h00;
        for (int t = 0; t < 16; t++) begin
            if (t < 8) e_b = tbl[2].seq[t];
            else       e_b = tbl[3].seq[t - 8];
            check("b2b_sout", sout0, e_b);
            check("b2b_ready", ready0, (t == 7) || (t == 15));
            check("b2b_frame", frame0, 1'b1);
            check("b2b_done", done0, (t == 7) || (t == 15));
            if (t == 8) din_valid = 1'b0;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // Reset during the third data bit
        din       = 6'h2A;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_pre_sout0", sout0, 1'b0);
        check("mid_pre_sout1", sout1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outs("mid_rst");
        @(negedge clk);
        check_reset_outs("mid_rst_held");
        rst_n = 1'b1;
        @(negedge clk);
        run_entry(tbl[0]);

        // Random traffic against the model
        repeat (3000) begin
            @(negedge clk);
            din_valid = ($urandom_range(0, 9) < 7);
            din       = W'($urandom);
        end
        @(negedge clk);
        din_valid = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_sum_serializer.md
Name: cla_sum_serializer

Overview:
- Transmit end of the CLA result path: takes a registered parallel word (5-bit sum plus carry-out) over a valid/ready handshake and sends it as a framed, LSB-first serial bitstream, one bit per CLK.
- Frame format: start bit, data bits, optional even-parity bit, stop bit.
- Sits after the CLA output register; its serial output feeds the matching serial capture block or the board pin.

Parameters:
- WIDTH, 6, data bits per frame (5 sum bits + carry-out); legal range 2..16.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset.
- DIN  input  WIDTH  parallel word; DIN[0] is sent first.
- DIN_VALID  input  1  DIN holds a word to send.
- DIN_READY  output  1  block can accept a word this cycle.
- SOUT  output  1  serial line; idles high.
- SOUT_FRAME  output  1  high for every bit period of a frame, start through stop inclusive.
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  one-cycle pulse during the stop-bit cycle.

Behaviour:
- Reset is asynchronous and active-low: RST_N low forces, without waiting for CLK:
  - state = IDLE, bit counter = 0, shift register = 0;
  - SOUT = 1, SOUT_FRAME = 0, BUSY = 0, DONE = 0, DIN_READY = 0.
- Reset release: DIN_READY rises after the first CLK edge with RST_N high.
- All outputs are driven from registers; no combinational path from DIN or DIN_VALID to any output.
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake:
  - Transfer occurs on a CLK edge where DIN_VALID = 1 and DIN_READY = 1. DIN is captured into the shift register on that edge.
  - DIN_READY = 1 only in IDLE and STOP.
  - DIN and DIN_VALID are ignored in all other states.
  - DIN_VALID may be asserted before DIN_READY; it must hold until the transfer.
- Transitions:
  - IDLE: transfer -> START; otherwise stay. SOUT = 1.
  - START: one cycle, SOUT = 0 -> DATA; counter = 0.
  - DATA: SOUT = shreg[0]; shift right and increment the counter each cycle.
    - After WIDTH cycles: -> PARITY if PARITY_EN = 1, else -> STOP.
  - PARITY: one cycle, SOUT = XOR of the captured word, i.e. even parity over data plus parity bit -> STOP.
  - STOP: one cycle, SOUT = 1, DONE = 1.
    - Transfer in this cycle -> START, giving back-to-back frames with exactly one stop bit.
    - Otherwise -> IDLE.
- Latency: transfer on edge k gives the start bit on SOUT in the cycle after edge k. Frame length is WIDTH+2 cycles, or WIDTH+3 with parity.
- Throughput: one word per WIDTH+2 (or WIDTH+3) cycles when DIN_VALID is held high.
- Counter width: ceil(log2(WIDTH+1)). Counter wraps to 0 on entry to START.
- Reset mid-frame: the frame is abandoned, SOUT returns high immediately, no DONE pulse.

Test Plan:
- Reset values: hold RST_N = 0 with DIN_VALID = 1 -> SOUT = 1, DIN_READY = 0, BUSY = 0, DONE = 0, SOUT_FRAME = 0 throughout; DIN_READY = 1 one edge after release.
- Single frame: WIDTH = 6, PARITY_EN = 0, DIN = 6'b101101 -> SOUT = 0,1,0,1,1,0,1,1 over 8 cycles; SOUT_FRAME high for those 8 cycles; DONE high only in cycle 8; then IDLE.
- Parity frame: PARITY_EN = 1, DIN = 6'b101101 -> parity bit 0. DIN = 6'b000111 -> parity bit 1. Frame length 9 cycles.
- Back-to-back: DIN_VALID held high with DIN = 6'h3F then 6'h00 -> second start bit directly follows the first stop bit; no idle-high gap; DIN_READY high only in IDLE and STOP cycles.
- Ignore while busy: change DIN to 6'h15 during the DATA state of a 6'h2A frame -> transmitted bits still 0,1,0,1,0,1.
- Mid-frame reset: assert RST_N = 0 during the 3rd data bit -> SOUT = 1 immediately (no clock edge), no DONE pulse; the next frame after release is bit-exact.
